// File: rtl/cpu_fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_fetch_pkg
// Description : Shared types and constants for the fetch PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Fetch sequencing states; HALT is only reachable with the misalign trap.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // One decoded-side buffer entry: the fetched word and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO with single-cycle flush. A pop and a
//               push in the same cycle are allowed when full; a pop on an
//               empty FIFO is ignored. DEPTH must be a power of two (>= 2).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = pop && (r_count != '0);
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign w_do_push = push && (!w_full || w_do_pop);

  // Storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Owns the fetch PC, issues in-order instruction-memory reads
//               under a credit limit, tags returned words with their PC and
//               buffers them for decode. Redirects flush the buffer and turn
//               every in-flight read into a discarded response.
//               Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned
//               redirect sets a sticky error and halts fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] next_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign_err
);

  localparam int CNT_W  = $clog2(IBUF_DEPTH+1);
  // Discard counter is wider than the credit window: repeated redirects
  // against a slow memory can stack several windows of dead responses.
  localparam int KILL_W = 16;

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [31:0]      r_pc;
  logic [KILL_W-1:0] r_kill_cnt;

  logic [CNT_W-1:0] w_tag_count;
  logic [CNT_W-1:0] w_buf_count;
  logic             w_tag_empty;
  logic             w_buf_empty;
  logic [31:0]      w_tag_head;
  fetch_entry_t     w_rsp_entry;
  fetch_entry_t     w_head;
  logic [CNT_W:0]   w_inflight;
  logic             w_accept;
  logic             w_killed;
  logic             w_live;
  logic             w_misalign;

  // Tag queue occupancy is exactly the number of live outstanding reads.
  assign w_inflight = {1'b0, w_tag_count} + {1'b0, w_buf_count};
  assign w_accept   = imem_req_valid && imem_req_ready;
  assign w_killed   = imem_rsp_valid && (r_kill_cnt != '0);
  assign w_live     = imem_rsp_valid && (r_kill_cnt == '0) && !w_tag_empty;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign_err;

  assign w_misalign = redirect_valid && (next_pc[1:0] != 2'b00) && (r_state != HALT);

  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_misalign_err <= 1'b0;
    else if (w_misalign) r_misalign_err <= 1'b1;
  end

  assign misalign_err = r_misalign_err;
`else
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // Next state and request issue; requests are withheld during a redirect.
  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = w_misalign ? HALT : RUN;
      RUN: begin
        imem_req_valid = (w_inflight < (CNT_W+1)'(IBUF_DEPTH)) && !redirect_valid;
        if (w_misalign) w_state_nxt = HALT;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = BOOT;
    endcase
  end

  // Fetch PC: redirect beats sequential increment; frozen once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid && (r_state != HALT)) begin
      r_pc <= w_misalign ? next_pc : (next_pc & ~32'h0000_0003);
    end else if (w_accept) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  // Dead-response counter: on redirect every read still owed to us becomes
  // a discard, on top of any discards already pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kill_cnt <= '0;
    end else if (redirect_valid) begin
      r_kill_cnt <= r_kill_cnt - KILL_W'(w_killed) + KILL_W'(w_tag_count)
                  - KILL_W'(w_live) + KILL_W'(w_accept);
    end else if (w_killed) begin
      r_kill_cnt <= r_kill_cnt - KILL_W'(1);
    end
  end

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (IBUF_DEPTH)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (w_accept),
    .push_data (r_pc),
    .pop       (w_live),
    .pop_data  (w_tag_head),
    .empty     (w_tag_empty),
    .count     (w_tag_count)
  );

  assign w_rsp_entry.pc    = w_tag_head;
  assign w_rsp_entry.instr = imem_rsp_data;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (w_live),
    .push_data (w_rsp_entry),
    .pop       (instr_ready),
    .pop_data  (w_head),
    .empty     (w_buf_empty),
    .count     (w_buf_count)
  );

  assign pc_out        = r_pc;
  assign imem_req_addr = r_pc;
  assign instr_valid   = !w_buf_empty;
  assign instr_data    = w_head.instr;
  assign instr_pc      = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Directed self-checking bench for fetch_pc_unit. Instance A
//               uses default parameters; instance B starts near the top of
//               the address space with a deeper buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        redirect_valid;
  logic [31:0] next_pc;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_ready;

  logic        a_req_valid, b_req_valid;
  logic [31:0] a_req_addr, b_req_addr;
  logic [31:0] a_pc, b_pc;
  logic        a_ivalid, b_ivalid;
  logic [31:0] a_idata, b_idata, a_ipc, b_ipc;
  logic        a_merr, b_merr;

  wire a_redirect = redirect_valid & ~sel;
  wire b_redirect = redirect_valid &  sel;
  wire a_ready    = imem_req_ready & ~sel;
  wire b_ready    = imem_req_ready &  sel;
  wire a_rsp      = imem_rsp_valid & ~sel;
  wire b_rsp      = imem_rsp_valid &  sel;

  wire        m_req_valid = sel ? b_req_valid : a_req_valid;
  wire [31:0] m_req_addr  = sel ? b_req_addr  : a_req_addr;
  wire [31:0] m_pc        = sel ? b_pc        : a_pc;
  wire        m_ivalid    = sel ? b_ivalid    : a_ivalid;
  wire [31:0] m_idata     = sel ? b_idata     : a_idata;
  wire [31:0] m_ipc       = sel ? b_ipc       : a_ipc;
  wire        m_merr      = sel ? b_merr      : a_merr;

  fetch_pc_unit u_dut_a (
    .clk (clk), .rst_n (rst_n), .pc_out (a_pc),
    .redirect_valid (a_redirect), .next_pc (next_pc),
    .imem_req_valid (a_req_valid), .imem_req_addr (a_req_addr),
    .imem_req_ready (a_ready), .imem_rsp_valid (a_rsp),
    .imem_rsp_data (imem_rsp_data), .instr_valid (a_ivalid),
    .instr_data (a_idata), .instr_pc (a_ipc),
    .instr_ready (instr_ready), .misalign_err (a_merr)
  );

  fetch_pc_unit #(
    .RESET_PC   (32'hFFFF_FFF8),
    .IBUF_DEPTH (4)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n), .pc_out (b_pc),
    .redirect_valid (b_redirect), .next_pc (next_pc),
    .imem_req_valid (b_req_valid), .imem_req_addr (b_req_addr),
    .imem_req_ready (b_ready), .imem_rsp_valid (b_rsp),
    .imem_rsp_data (imem_rsp_data), .instr_valid (b_ivalid),
    .instr_data (b_idata), .instr_pc (b_ipc),
    .instr_ready (instr_ready), .misalign_err (b_merr)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          lat = 1;
  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  logic        vld_log[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] data_at(input int i);
    return (i < got_data.size()) ? got_data[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    got_pc.delete();
    got_data.delete();
    vld_log.delete();
  endtask

  // One clock cycle: drive the memory response, sample outputs, clock.
  task automatic tick();
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_q[0].addr ^ MAGIC;
      void'(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (m_req_valid && imem_req_ready) begin
      req_log.push_back(m_req_addr);
      pend_q.push_back('{addr: m_req_addr, due: cyc + lat});
    end
    if (m_ivalid && instr_ready) begin
      got_pc.push_back(m_ipc);
      got_data.push_back(m_idata);
    end
    vld_log.push_back(m_ivalid);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    next_pc        = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b1;
    pend_q.delete();
    clear_logs();
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int bubbles;
    sel = 1'b0;

    // ---------------- reset values ----------------
    apply_reset();
    check_val("rst_pc",       a_pc,        32'h0);
    check_val("rst_req_valid", {31'b0, a_req_valid}, 32'h0);
    check_val("rst_ivalid",   {31'b0, a_ivalid},    32'h0);
    check_val("rst_idata",    a_idata,     32'h0);
    check_val("rst_ipc",      a_ipc,       32'h0);
    check_val("rst_merr",     {31'b0, a_merr},      32'h0);
    check_val("rst_pc_b",     b_pc,        32'hFFFF_FFF8);

    // ---------------- sequential stream ----------------
    lat = 1;
    release_reset();
    ticks(20);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("seq_req%0d", i),  req_at(i),  32'(i * 4));
      check_val($sformatf("seq_pc%0d", i),   pc_at(i),   32'(i * 4));
      check_val($sformatf("seq_data%0d", i), data_at(i), 32'(i * 4) ^ MAGIC);
    end

    // ---------------- decode stall ----------------
    apply_reset();
    instr_ready = 1'b0;
    release_reset();
    ticks(10);
    check_val("stall_nreq",      32'(req_log.size()), 32'd2);
    check_val("stall_req_valid", {31'b0, m_req_valid}, 32'h0);
    check_val("stall_ivalid",    {31'b0, m_ivalid},    32'h1);
    check_val("stall_ipc",       m_ipc,   32'h0);
    check_val("stall_idata",     m_idata, 32'h0 ^ MAGIC);
    instr_ready = 1'b1;
    ticks(6);
    check_val("resume_req2", req_at(2), 32'h8);
    check_val("resume_pc0",  pc_at(0),  32'h0);
    check_val("resume_pc1",  pc_at(1),  32'h4);
    check_val("resume_pc2",  pc_at(2),  32'h8);

    // ---------------- redirect with two reads outstanding ----------------
    apply_reset();
    lat = 3;
    release_reset();
    ticks(3);
    check_val("kill2_nreq", 32'(req_log.size()), 32'd2);
    redirect_valid = 1'b1;
    next_pc        = 32'h100;
    tick();
    redirect_valid = 1'b0;
    ticks(14);
    check_val("kill2_req2", req_at(2), 32'h100);
    check_val("kill2_pc0",  pc_at(0),  32'h100);
    check_val("kill2_d0",   data_at(0), 32'h100 ^ MAGIC);
    check_val("kill2_pc1",  pc_at(1),  32'h104);

    // ---------------- back-to-back redirects ----------------
    apply_reset();
    lat = 3;
    release_reset();
    ticks(3);
    redirect_valid = 1'b1;
    next_pc        = 32'h100;
    tick();
    next_pc        = 32'h300;
    tick();
    redirect_valid = 1'b0;
    ticks(14);
    check_val("b2b_req2", req_at(2), 32'h300);
    check_val("b2b_pc0",  pc_at(0),  32'h300);
    check_val("b2b_pc1",  pc_at(1),  32'h304);

    // ---------------- redirect coincident with a live response ----------------
    apply_reset();
    lat = 1;
    release_reset();
    ticks(2);
    redirect_valid = 1'b1;
    next_pc        = 32'h200;
    #1;
    check_val("live_req_gated", {31'b0, m_req_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    ticks(8);
    check_val("live_req1", req_at(1), 32'h200);
    check_val("live_pc0",  pc_at(0),  32'h200);
    check_val("live_pc1",  pc_at(1),  32'h204);

    // ---------------- misaligned redirect ----------------
    apply_reset();
    lat = 1;
    release_reset();
    ticks(3);
    redirect_valid = 1'b1;
    next_pc        = 32'h202;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    check_val("mis_pc",   m_pc, 32'h202);
    check_val("mis_err",  {31'b0, m_merr}, 32'h1);
    ticks(8);
    check_val("mis_nreq", 32'(req_log.size()), 32'd0);
    check_val("mis_req_valid", {31'b0, m_req_valid}, 32'h0);
    check_val("mis_ivalid", {31'b0, m_ivalid}, 32'h0);
    check_val("mis_err_sticky", {31'b0, m_merr}, 32'h1);
`else
    check_val("mis_pc",   m_pc, 32'h200);
    check_val("mis_err",  {31'b0, m_merr}, 32'h0);
    ticks(8);
    check_val("mis_req0", req_at(0), 32'h200);
    check_val("mis_pc0",  pc_at(0),  32'h200);
    check_val("mis_err_after", {31'b0, m_merr}, 32'h0);
`endif

    // ---------------- PC wrap on instance B, no bubbles ----------------
    apply_reset();
    sel = 1'b1;
    lat = 1;
    release_reset();
    ticks(12);
    check_val("wrap_req0", req_at(0), 32'hFFFF_FFF8);
    check_val("wrap_req1", req_at(1), 32'hFFFF_FFFC);
    check_val("wrap_req2", req_at(2), 32'h0000_0000);
    check_val("wrap_pc0",  pc_at(0),  32'hFFFF_FFF8);
    check_val("wrap_pc2",  pc_at(2),  32'h0000_0000);
    check_val("wrap_d2",   data_at(2), 32'h0 ^ MAGIC);
    bubbles = 0;
    for (int i = 3; i <= 10; i++) begin
      if (i >= vld_log.size() || !vld_log[i]) bubbles++;
    end
    check_val("wrap_bubbles", 32'(bubbles), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
